// File: rtl/alu_arbiter_pkg.sv
// Shared opcodes, FSM states and EXEC cycle counts for the two-requester ALU arbiter.
// Optional feature: define ALU_ARBITER_DIVZERO_EN to enable divide-by-zero detection.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam int EXEC_CYC_ALU  = 1;
  localparam int EXEC_CYC_MUL  = 2;
  localparam int EXEC_CYC_DIV  = 4;
  localparam int EXEC_CYC_RSVD = 1;

`ifdef ALU_ARBITER_DIVZERO_EN
  localparam bit DIVZERO_EN = 1'b1;
`else
  localparam bit DIVZERO_EN = 1'b0;
`endif

  // A zero divisor is only special when detection is built in.
  function automatic logic is_div_zero(input logic [2:0] op, input logic [15:0] b);
    return DIVZERO_EN && (op == OP_DIV) && (b == 16'h0000);
  endfunction

  // Counter load value: EXEC cycles minus one, so the last EXEC cycle sees zero.
  function automatic logic [1:0] exec_last(input logic [2:0] op, input logic [15:0] b);
    int cycles;
    case (op)
      OP_MUL:  cycles = EXEC_CYC_MUL;
      OP_DIV:  cycles = is_div_zero(op, b) ? EXEC_CYC_ALU : EXEC_CYC_DIV;
      OP_RSVD: cycles = EXEC_CYC_RSVD;
      default: cycles = EXEC_CYC_ALU;
    endcase
    return 2'(cycles - 1);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and external-ALU signals for alu_arbiter.
// slave = arbiter side; master = requesters, response sink and ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [2:0]  alu_control;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output alu_control, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  alu_control, alu_a, alu_b
  );
endinterface

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: ptr names the requester favoured when both are valid.
module alu_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic grant_id,
  output logic grant_valid
);

  assign grant_valid = valid0 | valid1;
  // With a single valid requester the grant goes to it regardless of ptr.
  assign grant_id    = (valid0 && valid1) ? ptr : valid1;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// IDLE -> EXEC -> RESP; ALU_ARBITER_DIVZERO_EN (see package) adds divide-by-zero detection.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus
);

  state_t      state_q, state_d;
  logic        rr_ptr_q;
  logic        id_q;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [1:0]  cnt_q;
  logic [15:0] result_q;
  logic        zero_q, err_q;

  logic        gnt_id, gnt_valid;
  logic        xfer, exec_done;
  logic        ready0, ready1, rsp_valid;
  logic [2:0]  alu_control;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  sel_op;
  logic [15:0] sel_a, sel_b;
  logic [15:0] cap_result;
  logic        cap_err;

  alu_rr_pick u_pick (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .ptr         (rr_ptr_q),
    .grant_id    (gnt_id),
    .grant_valid (gnt_valid)
  );

  assign sel_op    = gnt_id ? bus.req1_op : bus.req0_op;
  assign sel_a     = gnt_id ? bus.req1_a  : bus.req0_a;
  assign sel_b     = gnt_id ? bus.req1_b  : bus.req0_b;
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == 2'd0);

  // NOTE: every output gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d     = state_q;
    xfer        = 1'b0;
    ready0      = 1'b0;
    ready1      = 1'b0;
    rsp_valid   = 1'b0;
    alu_control = 3'b000;
    alu_a       = 16'h0000;
    alu_b       = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        // ready follows the granted valid, so valid&ready is just gnt_valid.
        if (gnt_valid) begin
          ready0  = ~gnt_id;
          ready1  = gnt_id;
          xfer    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_control = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        if (cnt_q == 2'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cap_result = bus.alu_result;
    cap_err    = 1'b0;
    if (op_q == OP_RSVD) begin
      cap_result = 16'h0000;
    end else if (is_div_zero(op_q, b_q)) begin
      cap_result = 16'hFFFF;
      cap_err    = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= 3'b000;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      cnt_q    <= 2'd0;
      result_q <= 16'h0000;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        id_q     <= gnt_id;
        op_q     <= sel_op;
        a_q      <= sel_a;
        b_q      <= sel_b;
        cnt_q    <= exec_last(sel_op, sel_b);
        rr_ptr_q <= ~gnt_id;
      end else if (state_q == ST_EXEC && cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (exec_done) begin
        result_q <= cap_result;
        zero_q   <= (cap_result == 16'h0000);
        err_q    <= cap_err;
      end
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_err     = err_q;
  assign bus.alu_control = alu_control;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level model of the arbiter's rules.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   fav      = 1'b0;   // requester the model expects to win a tie

`ifdef ALU_ARBITER_DIVZERO_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External ALU; reserved and div-by-zero return markers that must never leak when overridden.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return 16'(a * b);
      3'd6: return (b == 16'h0000) ? 16'h0BAD : a / b;
      default: return 16'hDEAD;
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_control, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] op, input logic [15:0] b);
    if (op == 3'd5) return 2;
    if (op == 3'd6) return (DZ && b == 16'h0000) ? 1 : 4;
    return 1;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                         input int stall);
    bit          gid;
    logic [2:0]  op;
    logic [15:0] a, b, res;
    bit          err;
    int          n;
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = 1'b0;
    @(negedge clk);
    if (!v0 && !v1) begin
      check("idle_ready0", bus.req0_ready, 0);
      check("idle_ready1", bus.req1_ready, 0);
      check("idle_rsp_valid", bus.rsp_valid, 0);
      @(posedge clk); #1;
      return;
    end
    gid = (v0 && v1) ? fav : v1;
    check("grant_ready0", bus.req0_ready, !gid);
    check("grant_ready1", bus.req1_ready, gid);
    fav = ~gid;
    op  = gid ? op1 : op0;
    a   = gid ? a1  : a0;
    b   = gid ? b1  : b0;
    n   = exp_cycles(op, b);
    err = DZ && op == 3'd6 && b == 16'h0000;
    res = (op == 3'd7) ? 16'h0000 : (err ? 16'hFFFF : alu_fn(op, a, b));
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("exec_alu_control", bus.alu_control, op);
      check("exec_alu_a", bus.alu_a, a);
      check("exec_alu_b", bus.alu_b, b);
      check("exec_rsp_valid", bus.rsp_valid, 0);
      check("exec_ready", {bus.req0_ready, bus.req1_ready}, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("resp_valid", bus.rsp_valid, 1);
      check("resp_id", bus.rsp_id, gid);
      check("resp_result", bus.rsp_result, res);
      check("resp_zero", bus.rsp_zero, res == 16'h0000);
      check("resp_err", bus.rsp_err, err);
      check("resp_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("resp_alu_idle", {bus.alu_control, bus.alu_a, bus.alu_b}, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {bus.req0_ready, bus.req1_ready}, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_fields"}, {bus.rsp_id, bus.rsp_zero, bus.rsp_err, bus.rsp_result}, 0);
    check({tag, "_alu"}, {bus.alu_control, bus.alu_a, bus.alu_b}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready  = 0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention: both valid throughout, grants alternate from requester 0.
    for (int i = 0; i < 4; i++) begin
      check("contention_fav", fav, i % 2);
      run_txn(1, 1, 3'd0, 16'(i), 16'd1, 3'd2, 16'hF0F0, 16'(i), 0);
    end

    // Single add, sub to zero, divide latency, reserved op.
    run_txn(1, 0, 3'd0, 16'd3, 16'd4, 3'd0, 16'd0, 16'd0, 0);
    run_txn(0, 1, 3'd0, 16'd0, 16'd0, 3'd1, 16'd5, 16'd5, 0);
    run_txn(0, 1, 3'd0, 16'd0, 16'd0, 3'd6, 16'd20, 16'd4, 0);
    run_txn(1, 0, 3'd7, 16'h1234, 16'h5678, 3'd0, 16'd0, 16'd0, 1);

    // Backpressure for 5 cycles, with the other requester waiting.
    run_txn(1, 1, 3'd5, 16'd300, 16'd300, 3'd4, 16'hAAAA, 16'h5555, 5);

    // Divide by zero: detected only when the feature is built in.
    run_txn(1, 0, 3'd6, 16'd9, 16'd0, 3'd0, 16'd0, 16'd0, 0);

    // Idle cycles with nothing valid.
    run_txn(0, 0, 3'd0, 16'd1, 16'd1, 3'd0, 16'd1, 16'd1, 0);

    // Reset mid-EXEC of a multiply from requester 0 (pointer then favours 1).
    bus.req0_valid = 1; bus.req0_op = 3'd5; bus.req0_a = 16'd7; bus.req0_b = 16'd6;
    bus.req1_valid = 0;
    @(negedge clk);
    check("mul_grant0", bus.req0_ready, 1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    @(negedge clk);
    check("mul_exec_alu", bus.alu_control, 3'd5);
    #2 rst = 1'b1;
    #1;
    check("midexec_rsp_valid", bus.rsp_valid, 0);
    check("midexec_alu", {bus.alu_control, bus.alu_a, bus.alu_b}, 0);
    @(negedge clk);
    rst  = 1'b0;
    fav  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_rsp_valid", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    run_txn(1, 1, 3'd3, 16'h00F0, 16'h0F00, 3'd0, 16'd1, 16'd2, 0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [15:0] a0, b0, a1, b1;
      a0 = 16'($urandom); b0 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      a1 = 16'($urandom); b1 = ($urandom_range(0, 7) == 0) ? a1 : 16'($urandom);
      if ($urandom_range(0, 9) == 0) b1 = 16'h0000;
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), a0, b0,
              3'($urandom_range(0, 7)), a1, b1,
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
